preview_fifo_frame_reader: RTL
==============================

Name: preview_fifo_frame_reader

Overview:
- Consumer at the read port of preview_fifo, the counterpart to the word writer.
- Pulls length-prefixed frames out of the FIFO using its show-ahead 1-word/2-word read interface.
- Reassembles each frame into a 2-lane output stream with sop/eop markers and a ready/valid handshake.
- Sits between a preview_fifo instance and downstream frame-processing logic, in the same clock domain.

Parameters:
- WIDTH, 8, data word width; must match the preview_fifo WIDTH.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rdreq  out  3  one-hot FIFO read request: 001 = none, 010 = pop 1 word, 100 = pop 2 words
- od0  in  WIDTH  FIFO head word (show-ahead)
- od1  in  WIDTH  FIFO word after head (show-ahead)
- empty  in  2  empty[0] = FIFO holds 0 words; empty[1] = FIFO holds fewer than 2 words
- out_data  out  2*WIDTH  lane0 = [WIDTH-1:0], lane1 = [2*WIDTH-1:WIDTH]
- out_vld  out  2  lane valid; legal values are 00, 01, 11
- out_sop  out  1  beat carries the first payload word of a frame
- out_eop  out  1  beat carries the last payload word of a frame
- out_rdy  in  1  downstream accepts the current beat
- frame_cnt  out  CNT_W  count of completed frames, wraps modulo 2^CNT_W
- busy  out  1  high while in the PAYLOAD state

Behaviour:
- Frame format: one header word, whose value L is the payload length (0..2^WIDTH-1), followed by L payload words.
- FIFO contract:
  - rdreq is combinational from registered state, empty, and od0.
  - A pop takes effect at the rising edge; od0/od1 show new head words in the next cycle.
  - rdreq never requests more words than empty indicates are present.
- Output register:
  - A beat is consumed when out_rdy is high and out_vld != 00.
  - can_load = (out_vld == 00) | out_rdy.
  - A payload pop loads the output register at the same edge, so output appears 1 cycle after the pop.
  - If out_rdy is high and no pop occurs, out_vld clears to 00 and sop/eop clear.
- State HDR:
  - If !empty[0]: rdreq = 010 (header pops alone, independent of can_load).
  - rem <= od0. If od0 != 0, go to PAYLOAD with first_flag = 1.
  - If od0 == 0, the header is dropped, the state stays HDR, and frame_cnt is unchanged.
  - If empty[0]: rdreq = 001.
- State PAYLOAD (rem is WIDTH bits wide):
  - If can_load & rem >= 2 & !empty[1]:
    - rdreq = 100; out_data <= {od1, od0}; out_vld <= 11; rem <= rem - 2.
  - Else if can_load & !empty[0]:
    - rdreq = 010; out_data lane0 <= od0, lane1 <= 0; out_vld <= 01; rem <= rem - 1.
    - This is the path when rem == 1, or when only 1 word is present.
  - Else: rdreq = 001; output register behaves per the hold/consume rule.
  - out_sop <= first_flag on every loaded beat; first_flag clears after the first load.
  - out_eop <= 1 when the new rem == 0. At that edge: go to HDR and increment frame_cnt.
- Next header read: a header pop is allowed in the cycle immediately after the eop load. Back-to-back frames incur exactly 1 header cycle.
- Hold: while out_rdy is low and out_vld != 00, out_data/out_vld/out_sop/out_eop stay stable and no payload pop occurs.
- Reset (any cycle, including mid-frame):
  - Next cycle: state = HDR; rem = 0; first_flag = 0; out_vld = 00; out_sop = out_eop = 0; out_data = 0; frame_cnt = 0; busy = 0.
  - rdreq = 001 combinationally while rst is high.
  - The partial frame is abandoned; its remaining FIFO words are not flushed.
- No pop is issued while empty indicates insufficient words, so FIFO underflow is impossible by construction.

Test Plan:
- FIFO = [04,A1,A2,A3,A4], out_rdy = 1:
  - rdreq sequence 010, 100, 100.
  - Beats: {A2,A1} vld = 11 sop = 1; then {A4,A3} vld = 11 eop = 1.
  - frame_cnt = 1.
- FIFO = [03,B1,B2,B3]:
  - rdreq sequence 010, 100, 010.
  - Beats: {B2,B1} vld = 11 sop; then {00,B3} vld = 01 eop.
- Starved FIFO, header 02 then words arriving one per 3 cycles with empty[1] always high:
  - Two 010 pops.
  - Beat 1: vld = 01 sop = 1 eop = 0. Beat 2: vld = 01 eop = 1.
- Frame len 4, out_rdy held low for 5 cycles after the first beat:
  - The first beat is stable for all 5 cycles and rdreq = 001 throughout.
  - The second beat loads on the cycle out_rdy rises.
- FIFO = [00,01,C1]: the zero header is popped and dropped; then a single beat {00,C1} with vld = 01, sop = 1, eop = 1; frame_cnt = 1.
- rst asserted after the first beat of a len-6 frame:
  - The next cycle shows out_vld = 00, busy = 0, frame_cnt = 0, rdreq = 001.
  - After rst falls, the next FIFO word is parsed as a header.

Source files
------------

// File: rtl/preview_fifo_frame_reader.sv
`default_nettype none
// ============================================================================
// preview_fifo_frame_reader: pops length-prefixed frames from a show-ahead
// FIFO and emits them as a 2-lane sop/eop stream.  Rev 1.0
// ============================================================================
module preview_fifo_frame_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [2:0]         rdreq,
  input  logic [WIDTH-1:0]   od0,
  input  logic [WIDTH-1:0]   od1,
  input  logic [1:0]         empty,
  output logic [2*WIDTH-1:0] out_data,
  output logic [1:0]         out_vld,
  output logic               out_sop,
  output logic               out_eop,
  input  logic               out_rdy,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic               busy
);

  typedef enum logic [0:0] {
    S_HDR     = 1'b0,
    S_PAYLOAD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               first_q, first_d;
  logic [2*WIDTH-1:0] data_q, data_d;
  logic [1:0]         vld_q, vld_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               w_can_load;
  logic               w_load;
  logic [WIDTH-1:0]   w_rem_next;

  assign w_can_load = (vld_q == 2'b00) | out_rdy;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    first_d    = first_q;
    data_d     = data_q;
    vld_d      = vld_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    cnt_d      = cnt_q;
    rdreq      = 3'b001;
    w_load     = 1'b0;
    w_rem_next = rem_q;

    case (state_q)
      S_HDR: begin
        // Header pops alone; zero-length headers are silently dropped.
        if (!empty[0]) begin
          rdreq = 3'b010;
          rem_d = od0;
          if (od0 != '0) begin
            state_d = S_PAYLOAD;
            first_d = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_can_load && (rem_q >= WIDTH'(2)) && !empty[1]) begin
          rdreq      = 3'b100;
          data_d     = {od1, od0};
          vld_d      = 2'b11;
          w_rem_next = rem_q - WIDTH'(2);
          w_load     = 1'b1;
        end else if (w_can_load && !empty[0]) begin
          rdreq      = 3'b010;
          data_d     = {{WIDTH{1'b0}}, od0};
          vld_d      = 2'b01;
          w_rem_next = rem_q - WIDTH'(1);
          w_load     = 1'b1;
        end
        if (w_load) begin
          rem_d   = w_rem_next;
          sop_d   = first_q;
          first_d = 1'b0;
          eop_d   = (w_rem_next == '0);
          if (w_rem_next == '0) begin
            state_d = S_HDR;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_HDR;
    endcase

    // Consumed beat with no replacement empties the output register.
    if (!w_load && out_rdy) begin
      vld_d = 2'b00;
      sop_d = 1'b0;
      eop_d = 1'b0;
    end

    if (rst) rdreq = 3'b001;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HDR;
      rem_q   <= '0;
      first_q <= 1'b0;
      data_q  <= '0;
      vld_q   <= 2'b00;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_vld   = vld_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign frame_cnt = cnt_q;
  assign busy      = (state_q == S_PAYLOAD);

endmodule
`default_nettype wire
